// File: rtl/wbm_byte_bridge_pkg.sv
// Shared definitions for the byte-stream to WISHBONE master bridge:
// response status codes, command byte layout, FSM states, byte counts.
package wbm_byte_bridge_pkg;

    localparam logic [7:0] ST_ACK     = 8'h00;
    localparam logic [7:0] ST_ERR     = 8'h01;
    localparam logic [7:0] ST_RTY     = 8'h02;
    localparam logic [7:0] ST_TIMEOUT = 8'h03;

    localparam int CMD_WE_BIT  = 7;
    localparam int CMD_SEL_MSB = 3;
    localparam int CMD_SEL_LSB = 0;

    // Byte counter runs 0..N-1 within a state; these are the final indices.
    localparam logic [1:0] ADDR_LAST = 2'd2;
    localparam logic [1:0] DATA_LAST = 2'd3;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_STAT,
        S_RDATA
    } state_t;

endpackage

// File: rtl/wbm_byte_bridge_if.sv
// Bundle of the bridge's byte-stream and WISHBONE master signals.
// master: bridge side; slave: transport/interconnect side.
interface wbm_byte_bridge_if #(
    parameter int ADDR_WIDTH = 20
);
    logic [7:0]            rx_dat_i;
    logic                  rx_valid_i;
    logic                  rx_ready_o;
    logic [7:0]            tx_dat_o;
    logic                  tx_valid_o;
    logic                  tx_ready_i;
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [31:0]           wb_dat_o;
    logic [3:0]            wb_sel_o;
    logic [31:0]           wb_dat_i;
    logic                  wb_ack_i;
    logic                  wb_err_i;
    logic                  wb_rty_i;

    modport master (
        input  rx_dat_i, rx_valid_i, tx_ready_i,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        output rx_ready_o, tx_dat_o, tx_valid_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    modport slave (
        output rx_dat_i, rx_valid_i, tx_ready_i,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        input  rx_ready_o, tx_dat_o, tx_valid_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/wbm_bridge_txser.sv
// Response serializer: loads a head byte (STATUS) plus a 32-bit word and
// emits bytes MSB first on a valid/ready stream. The caller flags the
// final byte with last_i so the same unit serves status-only responses.
module wbm_bridge_txser (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [7:0]  head_i,
    input  logic [31:0] word_i,
    input  logic        last_i,
    output logic [7:0]  tx_dat_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        fire_o
);
    logic [7:0]  cur_q;
    logic [31:0] sr_q;
    logic        vld_q;

    assign tx_dat_o   = cur_q;
    assign tx_valid_o = vld_q;
    assign fire_o     = vld_q & tx_ready_i;

    // Load on termination, advance one byte per accepted transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_q <= 8'h00;
            sr_q  <= 32'h0;
            vld_q <= 1'b0;
        end else if (load_i) begin
            cur_q <= head_i;
            sr_q  <= word_i;
            vld_q <= 1'b1;
        end else if (fire_o) begin
            cur_q <= sr_q[31:24];
            sr_q  <= {sr_q[23:0], 8'h00};
            vld_q <= !last_i;
        end
    end

endmodule

// File: rtl/wbm_byte_bridge.sv
// Byte-stream to WISHBONE master bridge: parses CMD/ADDR/WDATA packets,
// runs one classic cycle, returns STATUS (+ read data on ack'd reads).
// Optional macro WBM_BRIDGE_TIMEOUT_EN adds a bus-cycle timeout that
// returns status 0x03 after TIMEOUT_CYCLES cycles without termination.
module wbm_byte_bridge #(
    parameter int ADDR_WIDTH     = 20,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wbm_byte_bridge_if.master bus
);
    import wbm_byte_bridge_pkg::*;

    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 24 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("wbm_byte_bridge: ADDR_WIDTH must be 1..24, TIMEOUT_CYCLES >= 1");
    end

    state_t                state_q, state_d;
    logic [1:0]            cnt_q;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [31:0]           dat_q;
    logic                  rd_ok_q;

    logic                  rx_ready, rx_fire, tx_fire;
    logic                  term, tx_last, tmo_hit;
    logic [7:0]            status;

    assign rx_ready = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign rx_fire  = bus.rx_valid_i & rx_ready;

    assign bus.rx_ready_o = rx_ready;
    assign bus.wb_cyc_o   = (state_q == S_BUS);
    assign bus.wb_stb_o   = (state_q == S_BUS);
    assign bus.wb_we_o    = we_q;
    assign bus.wb_adr_o   = adr_q;
    assign bus.wb_dat_o   = dat_q;
    assign bus.wb_sel_o   = sel_q;

`ifdef WBM_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    // Cycles spent in BUS; zero whenever the cycle is not active.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                 tmo_q <= '0;
        else if (state_q != S_BUS) tmo_q <= '0;
        else                       tmo_q <= tmo_q + 1'b1;
    end

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_CMD;
        else       state_q <= state_d;
    end

    // Next state, termination decode (err > rty > ack > timeout), tx last flag.
    always_comb begin
        state_d = state_q;
        status  = ST_ACK;
        term    = 1'b0;
        tx_last = 1'b0;
        case (state_q)
            S_CMD:   if (rx_fire) state_d = S_ADDR;
            S_ADDR:  if (rx_fire && cnt_q == ADDR_LAST) state_d = we_q ? S_WDATA : S_BUS;
            S_WDATA: if (rx_fire && cnt_q == DATA_LAST) state_d = S_BUS;
            S_BUS: begin
                term = 1'b1;
                if (bus.wb_err_i)      status = ST_ERR;
                else if (bus.wb_rty_i) status = ST_RTY;
                else if (bus.wb_ack_i) status = ST_ACK;
                else if (tmo_hit)      status = ST_TIMEOUT;
                else                   term   = 1'b0;
                if (term) state_d = S_STAT;
            end
            S_STAT: begin
                tx_last = !rd_ok_q;
                if (tx_fire) state_d = rd_ok_q ? S_RDATA : S_CMD;
            end
            S_RDATA: begin
                tx_last = (cnt_q == DATA_LAST);
                if (tx_fire && tx_last) state_d = S_CMD;
            end
            default: state_d = S_CMD;
        endcase
    end

    // Byte index within the current state; restarts on every state change.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                     cnt_q <= 2'd0;
        else if (state_d != state_q)   cnt_q <= 2'd0;
        else if (rx_fire || tx_fire)   cnt_q <= cnt_q + 2'd1;
    end

    // Request fields shift in MSB first; address keeps the low ADDR_WIDTH bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= '0;
            dat_q   <= 32'h0;
            rd_ok_q <= 1'b0;
        end else begin
            if (rx_fire) begin
                case (state_q)
                    S_CMD: begin
                        we_q  <= bus.rx_dat_i[CMD_WE_BIT];
                        sel_q <= bus.rx_dat_i[CMD_SEL_MSB:CMD_SEL_LSB];
                    end
                    S_ADDR:  adr_q <= ADDR_WIDTH'({adr_q, bus.rx_dat_i});
                    S_WDATA: dat_q <= {dat_q[23:0], bus.rx_dat_i};
                    default: ;
                endcase
            end
            if (term) rd_ok_q <= !we_q && (status == ST_ACK);
        end
    end

    wbm_bridge_txser u_txser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (term),
        .head_i     (status),
        .word_i     (bus.wb_dat_i),
        .last_i     (tx_last),
        .tx_dat_o   (bus.tx_dat_o),
        .tx_valid_o (bus.tx_valid_o),
        .tx_ready_i (bus.tx_ready_i),
        .fire_o     (tx_fire)
    );

endmodule

// File: tb/tb_wbm_byte_bridge.sv
// Directed bench for wbm_byte_bridge with a behavioural WISHBONE slave.
// Timeout scenario is exercised only when WBM_BRIDGE_TIMEOUT_EN is defined.
module tb_wbm_byte_bridge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wbm_byte_bridge_if #(.ADDR_WIDTH(20)) bif();

    wbm_byte_bridge #(.ADDR_WIDTH(20), .TIMEOUT_CYCLES(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    int checks   = 0;
    int failures = 0;

    // Slave model controls: mode 0 ack, 1 err+ack, 2 rty, 3 never terminate.
    int          slv_mode      = 0;
    int          slv_wait      = 0;
    logic [31:0] slv_rdata     = 32'h0;
    logic        slv_force_ack = 1'b0;
    // Slave observations of the last bus cycle.
    int          cyc_cnt  = 0;
    logic        unstable = 1'b0;
    logic [56:0] cap      = '0;   // {we, sel, adr, dat}

    initial begin : slave
        int   wcnt;
        logic prev_cyc;
        logic hit;
        wcnt = 0;
        prev_cyc = 1'b0;
        bif.wb_ack_i = 1'b0;
        bif.wb_err_i = 1'b0;
        bif.wb_rty_i = 1'b0;
        bif.wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            bif.wb_dat_i = slv_rdata;
            if (bif.wb_cyc_o && bif.wb_stb_o) begin
                if (!prev_cyc) begin
                    cyc_cnt  = 1;
                    wcnt     = 0;
                    unstable = 1'b0;
                    cap      = {bif.wb_we_o, bif.wb_sel_o, bif.wb_adr_o, bif.wb_dat_o};
                end else begin
                    cyc_cnt++;
                    wcnt++;
                    if ({bif.wb_we_o, bif.wb_sel_o, bif.wb_adr_o, bif.wb_dat_o} !== cap)
                        unstable = 1'b1;
                end
                hit = (wcnt >= slv_wait);
                bif.wb_ack_i = hit && (slv_mode == 0 || slv_mode == 1);
                bif.wb_err_i = hit && (slv_mode == 1);
                bif.wb_rty_i = hit && (slv_mode == 2);
            end else begin
                bif.wb_ack_i = slv_force_ack;
                bif.wb_err_i = 1'b0;
                bif.wb_rty_i = 1'b0;
            end
            prev_cyc = bif.wb_cyc_o;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bif.rx_dat_i   = b;
        bif.rx_valid_i = 1'b1;
        while (!bif.rx_ready_o && n < 200) begin @(negedge clk); n++; end
        if (!bif.rx_ready_o) begin
            checks++; failures++;
            $display("FAIL rx_accept_timeout byte=%h", b);
        end
        @(posedge clk);
        @(negedge clk);
        bif.rx_valid_i = 1'b0;
    endtask

    task automatic send_req(input logic [7:0] cmd, input logic [23:0] adr, input logic [31:0] dat);
        send_byte(cmd);
        send_byte(adr[23:16]); send_byte(adr[15:8]); send_byte(adr[7:0]);
        if (cmd[7]) begin
            send_byte(dat[31:24]); send_byte(dat[23:16]);
            send_byte(dat[15:8]);  send_byte(dat[7:0]);
        end
    endtask

    task automatic get_resp(output logic [7:0] b, output int gap);
        int n = 0;
        while (!bif.tx_valid_o && n < 200) begin @(negedge clk); n++; end
        gap = n;
        if (!bif.tx_valid_o) begin
            checks++; failures++;
            $display("FAIL tx_valid_timeout waited=%0d", n);
        end
        b = bif.tx_dat_o;
        bif.tx_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.tx_ready_i = 1'b0;
    endtask

    task automatic wait_cyc_fall();
        int n = 0;
        while (bif.wb_cyc_o && n < 200) begin @(negedge clk); n++; end
        if (bif.wb_cyc_o) begin
            checks++; failures++;
            $display("FAIL cyc_fall_timeout waited=%0d", n);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bif.wb_cyc_o, bif.wb_stb_o, bif.wb_we_o, bif.tx_valid_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                     {bif.wb_cyc_o, bif.wb_stb_o, bif.wb_we_o, bif.tx_valid_o});
        end
        checks++;
        if (bif.rx_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_rx_ready got=%b exp=1", bif.rx_ready_o);
        end
        checks++;
        if ({bif.wb_adr_o, bif.wb_dat_o, bif.wb_sel_o, bif.tx_dat_o} !== 64'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0",
                     {bif.wb_adr_o, bif.wb_dat_o, bif.wb_sel_o, bif.tx_dat_o});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] b;
        int g;
        slv_mode = 0; slv_wait = 2;
        send_req(8'h8F, 24'h012345, 32'hDEADBEEF);
        checks++;
        if (bif.wb_cyc_o !== 1'b1) begin
            failures++; $display("FAIL wr_cyc_start got=%b exp=1", bif.wb_cyc_o);
        end
        wait_cyc_fall();
        checks++;
        if ({bif.tx_valid_o, bif.tx_dat_o} !== 9'h100) begin
            failures++;
            $display("FAIL wr_status_timing got=%h exp=100", {bif.tx_valid_o, bif.tx_dat_o});
        end
        checks++;
        if (cyc_cnt !== 3) begin
            failures++; $display("FAIL wr_cyc_len got=%0d exp=3", cyc_cnt);
        end
        checks++;
        if (cap !== {1'b1, 4'hF, 20'h12345, 32'hDEADBEEF}) begin
            failures++; $display("FAIL wr_bus_fields got=%h exp=%h", cap,
                                 {1'b1, 4'hF, 20'h12345, 32'hDEADBEEF});
        end
        checks++;
        if (unstable !== 1'b0) begin
            failures++; $display("FAIL wr_bus_stable got=%b exp=0", unstable);
        end
        get_resp(b, g);
        checks++;
        if (b !== 8'h00) begin
            failures++; $display("FAIL wr_status got=%h exp=00", b);
        end
        checks++;
        if ({bif.rx_ready_o, bif.tx_valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL wr_done got=%b exp=10", {bif.rx_ready_o, bif.tx_valid_o});
        end
    endtask

    task automatic test_read();
        logic [7:0] b;
        logic [7:0] exp[5];
        int g;
        exp = '{8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        slv_mode = 0; slv_wait = 0; slv_rdata = 32'hCAFEF00D;
        send_req(8'h0F, 24'h030010, 32'h0);
        wait_cyc_fall();
        checks++;
        if (cyc_cnt !== 1) begin
            failures++; $display("FAIL rd_cyc_len got=%0d exp=1", cyc_cnt);
        end
        checks++;
        if (cap[56:32] !== {1'b0, 4'hF, 20'h30010}) begin
            failures++; $display("FAIL rd_bus_fields got=%h exp=%h", cap[56:32],
                                 {1'b0, 4'hF, 20'h30010});
        end
        for (int i = 0; i < 5; i++) begin
            get_resp(b, g);
            checks++;
            if (b !== exp[i] || (i > 0 && g != 0)) begin
                failures++;
                $display("FAIL rd_byte%0d got=%h gap=%0d exp=%h gap=0", i, b, g, exp[i]);
            end
        end
        checks++;
        if ({bif.rx_ready_o, bif.tx_valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL rd_done got=%b exp=10", {bif.rx_ready_o, bif.tx_valid_o});
        end
    endtask

    task automatic test_err_rty();
        logic [7:0] b;
        int g;
        for (int m = 1; m <= 2; m++) begin
            slv_mode = m; slv_wait = 0; slv_rdata = 32'h99887766;
            send_req(8'h05, 24'h000100, 32'h0);
            wait_cyc_fall();
            get_resp(b, g);
            checks++;
            if (b !== 8'(m)) begin
                failures++; $display("FAIL term_status mode=%0d got=%h exp=%h", m, b, 8'(m));
            end
            checks++;
            if ({bif.rx_ready_o, bif.tx_valid_o} !== 2'b10) begin
                failures++; $display("FAIL term_status_only mode=%0d got=%b exp=10", m,
                                     {bif.rx_ready_o, bif.tx_valid_o});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        logic [7:0] exp[5];
        logic held;
        int g;
        slv_mode = 0; slv_wait = 0; slv_rdata = 32'h12345678;
        send_req(8'h0F, 24'h000200, 32'h0);
        wait_cyc_fall();
        get_resp(b, g);
        get_resp(b, g);
        checks++;
        if (b !== 8'h12) begin
            failures++; $display("FAIL bp_first got=%h exp=12", b);
        end
        // Offer the next command while the response is stalled.
        bif.rx_dat_i = 8'h0F; bif.rx_valid_i = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(bif.tx_valid_o === 1'b1 && bif.tx_dat_o === 8'h34 && bif.rx_ready_o === 1'b0))
                held = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (held !== 1'b1) begin
            failures++; $display("FAIL bp_hold got=%b exp=1", held);
        end
        exp = '{8'h34, 8'h56, 8'h78, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            get_resp(b, g);
            checks++;
            if (b !== exp[i]) begin
                failures++; $display("FAIL bp_byte%0d got=%h exp=%h", i, b, exp[i]);
            end
        end
        // The waiting command byte must land now, then finish the packet.
        slv_rdata = 32'h0A0B0C0D;
        send_byte(8'h0F);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h04);
        wait_cyc_fall();
        checks++;
        if (cap[56:32] !== {1'b0, 4'hF, 20'h00204}) begin
            failures++; $display("FAIL bp_next_adr got=%h exp=%h", cap[56:32],
                                 {1'b0, 4'hF, 20'h00204});
        end
        exp = '{8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
        for (int i = 0; i < 5; i++) begin
            get_resp(b, g);
            checks++;
            if (b !== exp[i]) begin
                failures++; $display("FAIL bp_next_byte%0d got=%h exp=%h", i, b, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int g;
        send_byte(8'h8F); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'hAA);
        rst = 1'b1;
        #1;
        checks++;
        if ({bif.rx_ready_o, bif.wb_adr_o, bif.wb_dat_o, bif.wb_sel_o} !== {1'b1, 56'h0}) begin
            failures++; $display("FAIL rst_mid_packet got=%h exp=%h",
                {bif.rx_ready_o, bif.wb_adr_o, bif.wb_dat_o, bif.wb_sel_o}, {1'b1, 56'h0});
        end
        @(negedge clk);
        rst = 1'b0;
        slv_mode = 3;
        send_req(8'h0F, 24'h000040, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (bif.wb_cyc_o !== 1'b1) begin
            failures++; $display("FAIL rst_bus_active got=%b exp=1", bif.wb_cyc_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bif.wb_cyc_o, bif.wb_stb_o, bif.tx_valid_o, bif.wb_we_o} !== 4'b0000) begin
            failures++; $display("FAIL rst_async_cyc got=%b exp=0000",
                {bif.wb_cyc_o, bif.wb_stb_o, bif.tx_valid_o, bif.wb_we_o});
        end
        @(negedge clk);
        rst = 1'b0;
        slv_mode = 0; slv_wait = 1;
        send_req(8'h83, 24'hFABCDE, 32'h11223344);
        wait_cyc_fall();
        checks++;
        if (cyc_cnt !== 2 || cap !== {1'b1, 4'h3, 20'hABCDE, 32'h11223344}) begin
            failures++; $display("FAIL rst_after_write got=%0d/%h exp=2/%h", cyc_cnt, cap,
                                 {1'b1, 4'h3, 20'hABCDE, 32'h11223344});
        end
        get_resp(b, g);
        checks++;
        if (b !== 8'h00 || bif.rx_ready_o !== 1'b1) begin
            failures++; $display("FAIL rst_after_status got=%h/%b exp=00/1", b, bif.rx_ready_o);
        end
    endtask

`ifdef WBM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] b;
        logic [7:0] exp[5];
        logic quiet;
        int g;
        slv_mode = 3;
        send_req(8'h0F, 24'h000044, 32'h0);
        wait_cyc_fall();
        checks++;
        if (cyc_cnt !== 16 || {bif.tx_valid_o, bif.tx_dat_o} !== 9'h103) begin
            failures++; $display("FAIL tmo_cycle got=%0d/%h exp=16/103", cyc_cnt,
                                 {bif.tx_valid_o, bif.tx_dat_o});
        end
        get_resp(b, g);
        checks++;
        if (b !== 8'h03 || {bif.rx_ready_o, bif.tx_valid_o} !== 2'b10) begin
            failures++; $display("FAIL tmo_status_only got=%h/%b exp=03/10", b,
                                 {bif.rx_ready_o, bif.tx_valid_o});
        end
        slv_force_ack = 1'b1;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bif.wb_cyc_o !== 1'b0 || bif.tx_valid_o !== 1'b0 || bif.rx_ready_o !== 1'b1)
                quiet = 1'b0;
        end
        slv_force_ack = 1'b0;
        checks++;
        if (quiet !== 1'b1) begin
            failures++; $display("FAIL tmo_late_ack got=%b exp=1", quiet);
        end
        slv_mode = 0; slv_wait = 0; slv_rdata = 32'h55AA33CC;
        send_req(8'h0F, 24'h000048, 32'h0);
        wait_cyc_fall();
        exp = '{8'h00, 8'h55, 8'hAA, 8'h33, 8'hCC};
        for (int i = 0; i < 5; i++) begin
            get_resp(b, g);
            checks++;
            if (b !== exp[i]) begin
                failures++; $display("FAIL tmo_next_byte%0d got=%h exp=%h", i, b, exp[i]);
            end
        end
    endtask
`endif

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bif.rx_dat_i   = 8'h00;
        bif.rx_valid_i = 1'b0;
        bif.tx_ready_i = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_err_rty();
        test_backpressure();
        test_reset_mid();
`ifdef WBM_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
